// File: rtl/oled_pkg.sv
// ---------------------------------------------------------------------------
// oled_pkg
// Types and constants shared by the SSD1306 OLED transmit path and its
// receive-side loopback sink.
//   oled_byte_t : one bus byte plus the D/nC level captured with it
//   OLED_CMD    : D/nC level that marks a command byte
//   OLED_DATA   : D/nC level that marks a display data byte
// ---------------------------------------------------------------------------
package oled_pkg;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } oled_byte_t;

  localparam logic OLED_CMD  = 1'b0;
  localparam logic OLED_DATA = 1'b1;

  localparam int OLED_BYTE_W = $bits(oled_byte_t);

endpackage

// File: rtl/ssd1306_spi_sink_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with extra-wrap-bit pointers and a first-word view of the
// head entry.
//   clk, reset : system clock, synchronous active-high reset
//   push/wdata : write request and entry; ignored while full unless a pop
//                happens in the same cycle
//   pop        : read request; ignored while empty
//   rdata      : head entry (valid when empty is low)
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // The extra pointer bit separates "same slot, same lap" (empty) from
  // "same slot, one lap apart" (full).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = mem[rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the head reads as zero before any write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/ssd1306_spi_sink.sv
// ---------------------------------------------------------------------------
// ssd1306_spi_sink
// SPI target that oversamples the four-wire SSD1306 bus with the system clock
// and recovers each byte together with its command/data tag, for loopback
// checking of the OLED transmitter.
//   clk, reset      : system clock (>= 4x SPI clock), synchronous active-high
//   spi_ncs         : chip select, active low, asynchronous
//   spi_clk         : SPI clock, mode 0 (MOSI sampled on rising edge)
//   spi_mosi        : serial data, MSB first
//   spi_dnc         : 0 = command byte, 1 = data byte
//   out_valid/ready : valid/ready handshake on the FIFO head
//   out_data/out_dc : head byte and the D/nC level captured with its bit 0
//   overflow        : sticky, a byte completed while the FIFO was full
//   abort           : one-cycle pulse, chip select released mid-byte
//   busy            : synchronized chip select is asserted
// ---------------------------------------------------------------------------
module ssd1306_spi_sink
  import oled_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_ncs,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_dnc,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_dc,
  output logic       overflow,
  output logic       abort,
  output logic       busy
);

  logic       ncs_s1, ncs_s2, ncs_s3;
  logic       sck_s1, sck_s2, sck_s3;
  logic       mosi_s1, mosi_s2;
  logic       dnc_s1, dnc_s2;
  logic       rise;
  logic       ncs_rise;

  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [7:0] next_byte;
  logic       byte_done;
  oled_byte_t byte_reg;

  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  oled_byte_t fifo_head;

  // Two-flop synchronizers on every bus line, plus a third stage on SCK and
  // nCS for edge detection. nCS resets high so a reset never looks like a
  // chip-select release.
  always_ff @(posedge clk) begin
    if (reset) begin
      ncs_s1  <= 1'b1;
      ncs_s2  <= 1'b1;
      ncs_s3  <= 1'b1;
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_s3  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      dnc_s1  <= 1'b0;
      dnc_s2  <= 1'b0;
    end else begin
      ncs_s1  <= spi_ncs;
      ncs_s2  <= ncs_s1;
      ncs_s3  <= ncs_s2;
      sck_s1  <= spi_clk;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      mosi_s1 <= spi_mosi;
      mosi_s2 <= mosi_s1;
      dnc_s1  <= spi_dnc;
      dnc_s2  <= dnc_s1;
    end
  end

  assign rise      = sck_s2 & ~sck_s3;
  assign ncs_rise  = ncs_s2 & ~ncs_s3;
  assign busy      = ~ncs_s2;
  assign next_byte = {shift_reg[6:0], mosi_s2};

  // Bit assembly. A chip-select release takes priority and drops any partial
  // byte; SCK edges seen while deselected never touch the counter, so the
  // next frame always starts bit-aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      byte_done <= 1'b0;
      byte_reg  <= '0;
      abort     <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      abort     <= 1'b0;
      if (ncs_rise) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
        abort     <= (bit_cnt != 3'd0);
      end else if (rise && !ncs_s2) begin
        shift_reg <= next_byte;
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done     <= 1'b1;
          byte_reg.data <= next_byte;
          byte_reg.dc   <= dnc_s2;
        end
      end
    end
  end

  assign fifo_pop = out_valid & out_ready;

  sync_fifo #(
    .WIDTH (OLED_BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (byte_done),
    .wdata (byte_reg),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_head.data;
  assign out_dc    = fifo_head.dc;

  // A completed byte is lost only when the FIFO is full and nothing leaves
  // in the same cycle; once seen, the loss stays flagged until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (byte_done && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
// ---------------------------------------------------------------------------
// tb_ssd1306_spi_sink
// Drives SSD1306-style SPI frames at clk/8 into ssd1306_spi_sink and checks
// recovered bytes against a queue of expected {dc, data} entries, plus
// latency, overflow, abort and reset behaviour.
// ---------------------------------------------------------------------------
module tb_ssd1306_spi_sink;
  import oled_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_ncs;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_dnc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_dc;
  logic       overflow;
  logic       abort;
  logic       busy;

  int         assert_count = 0;
  int         fail_count = 0;
  int         cycle = 0;
  int         abort_count = 0;
  int         last_rise_cycle = 0;
  int         first_valid_cycle = -1;
  logic       prev_valid = 1'b0;
  oled_byte_t exp_q[$];
  oled_byte_t mon_exp;

  ssd1306_spi_sink #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .spi_ncs   (spi_ncs),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_dnc   (spi_dnc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_dc    (out_dc),
    .overflow  (overflow),
    .abort     (abort),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Output side: every accepted head entry is matched against the queue;
  // abort pulses and the first out_valid rise are recorded for later checks.
  always @(negedge clk) begin
    if (!reset) begin
      if (abort) abort_count++;
      if (out_valid && !prev_valid && first_valid_cycle < 0)
        first_valid_cycle = cycle;
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        checkOutput("sb_has_entry", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          checkOutput("out_dc", 32'(out_dc), 32'(mon_exp.dc));
          checkOutput("out_data", 32'(out_data), 32'(mon_exp.data));
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Sends the top nbits of data MSB first, mode 0, half period 40 ns.
  task automatic applyStimulus(input logic [7:0] data, input logic dc,
                               input int nbits, input bit keep);
    oled_byte_t e;
    if (keep && nbits == 8) begin
      e.dc   = dc;
      e.data = data;
      exp_q.push_back(e);
    end
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = data[i];
      spi_dnc  = dc;
      #40;
      spi_clk = 1'b1;
      if (i == 0) last_rise_cycle = cycle;
      #40;
      spi_clk = 1'b0;
    end
  endtask

  task automatic csLow();
    spi_ncs = 1'b0;
    #40;
  endtask

  task automatic csHigh();
    #40;
    spi_ncs = 1'b1;
    #80;
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    checkOutput(tag, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    spi_ncs   = 1'b1;
    spi_clk   = 1'b0;
    spi_mosi  = 1'b0;
    spi_dnc   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_data", 32'(out_data), 0);
    checkOutput("rst_out_dc", 32'(out_dc), 0);
    checkOutput("rst_overflow", 32'(overflow), 0);
    checkOutput("rst_abort", 32'(abort), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single command byte and its latency from the last sampled SCK rise.
    $display("[TB] single command byte 0xAE");
    first_valid_cycle = -1;
    csLow();
    checkOutput("busy_selected", 32'(busy), 1);
    applyStimulus(8'hAE, OLED_CMD, 8, 1'b1);
    csHigh();
    waitDrain("drain_single");
    checkOutput("latency", 32'(first_valid_cycle - last_rise_cycle - 1), 3);
    checkOutput("abort_after_single", abort_count, 0);
    checkOutput("busy_released", 32'(busy), 0);

    // Mixed command/data bytes in one frame.
    $display("[TB] three bytes in one frame");
    csLow();
    applyStimulus(8'h81, OLED_CMD, 8, 1'b1);
    applyStimulus(8'h7F, OLED_DATA, 8, 1'b1);
    applyStimulus(8'hA5, OLED_DATA, 8, 1'b1);
    csHigh();
    waitDrain("drain_frame");

    // Five bytes into a stalled consumer: only four fit.
    $display("[TB] overflow with stalled consumer");
    out_ready = 1'b0;
    csLow();
    for (int b = 1; b <= 5; b++)
      applyStimulus(8'(b), OLED_DATA, 8, b <= 4);
    csHigh();
    checkOutput("overflow_set", 32'(overflow), 1);
    checkOutput("full_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    waitDrain("drain_overflow");
    repeat (10) @(posedge clk);
    #1;
    checkOutput("overflow_sticky", 32'(overflow), 1);
    checkOutput("valid_after_drain", 32'(out_valid), 0);

    // Partial byte then a clean frame.
    $display("[TB] abort on partial byte");
    csLow();
    applyStimulus(8'hE0, OLED_CMD, 3, 1'b0);
    csHigh();
    checkOutput("abort_pulse", abort_count, 1);
    csLow();
    applyStimulus(8'h3C, OLED_DATA, 8, 1'b1);
    csHigh();
    waitDrain("drain_after_abort");
    checkOutput("abort_once", abort_count, 1);

    // SCK activity while deselected must be ignored.
    $display("[TB] clocks while deselected");
    applyStimulus(8'hFF, OLED_DATA, 8, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("deselected_valid", 32'(out_valid), 0);
    checkOutput("deselected_abort", abort_count, 1);

    // Reset in the middle of a byte, then a full byte.
    $display("[TB] reset mid-byte");
    csLow();
    applyStimulus(8'hF8, OLED_CMD, 5, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("overflow_cleared", 32'(overflow), 0);
    #40;
    applyStimulus(8'h55, OLED_DATA, 8, 1'b1);
    csHigh();
    waitDrain("drain_after_reset");
    checkOutput("overflow_after_reset", 32'(overflow), 0);
    checkOutput("abort_after_reset", abort_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
